// File: rtl/sd_ctrl_pkg.sv
// Shared types and constants for the SD block-read sequencer and its response FIFO.
package sd_ctrl_pkg;

    localparam int SD_WORD_W   = 32;
    localparam int SD_READ_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETADDR,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sd_resp_fifo.sv
// Synchronous FIFO holding {last, data} words on their way to the consumer.
// No bypass: a word pushed this cycle becomes visible at the head next cycle.
module sd_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push_i);
            rd_q    <= rd_q + AW'(pop_i);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/sd_read_ctrl.sv
// Block-read sequencer for the SD helper: one setAddr, then one ren per word,
// streaming captured words to a consumer through a credit-limited FIFO.
import sd_ctrl_pkg::*;

module sd_read_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SD_WORD_W-1:0] req_addr,
    input  logic [LEN_W-1:0]     req_len,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [SD_WORD_W-1:0] resp_data,
    output logic                 resp_last,
    output logic                 done,
    output logic                 busy,
    output logic                 sd_setAddr,
    output logic [SD_WORD_W-1:0] sd_addr,
    output logic                 sd_ren,
    input  logic [SD_WORD_W-1:0] sd_data,
    output state_t               dbg_state
);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid never depends combinationally on ready.

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 setaddr_q, setaddr_d;
    logic [SD_WORD_W-1:0] addr_q, addr_d;
    logic                 ren_q, ren_d;

    logic                 push, push_last, pop, fifo_empty;
    logic [CW-1:0]        fifo_count, cnt_next;
    logic [SD_WORD_W:0]   head;

    // ren_q doubles as the in-flight flag: the word requested this cycle is
    // captured and pushed at the edge that ends the cycle.
    assign push      = ren_q;
    assign push_last = ren_q && (rem_q == LEN_W'(1));
    assign pop       = resp_valid && resp_ready;
    assign cnt_next  = fifo_count + CW'(push) - CW'(pop);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        setaddr_d = 1'b0;
        addr_d    = '0;
        if (ren_q) begin
            rem_d = rem_q - LEN_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rem_d = req_len;
                    if (req_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = SETADDR;
                        setaddr_d = 1'b1;
                        addr_d    = req_addr;
                    end
                end
            end
            SETADDR: state_d = READ;
            READ:    if (push_last) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Issue the next ren only if its word is guaranteed a free FIFO slot.
        ren_d = (state_d == READ) && (rem_d != '0) && (cnt_next < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            setaddr_q <= 1'b0;
            addr_q    <= '0;
            ren_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            setaddr_q <= setaddr_d;
            addr_q    <= addr_d;
            ren_q     <= ren_d;
        end
    end

    sd_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SD_WORD_W + 1)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .push_data_i ({push_last, sd_data}),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign resp_data  = resp_valid ? head[SD_WORD_W-1:0] : '0;
    assign resp_last  = resp_valid && head[SD_WORD_W];
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign sd_setAddr = setaddr_q;
    assign sd_addr    = addr_q;
    assign sd_ren     = ren_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sd_read_ctrl.sv
// Directed bench for sd_read_ctrl with a behavioural SD helper and a
// scoreboard of expected {last, data} words.
module tb_sd_read_ctrl;
    import sd_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_data;
    logic          resp_last;
    logic          done;
    logic          busy;
    logic          sd_setAddr;
    logic [31:0]   sd_addr;
    logic          sd_ren;
    logic [31:0]   sd_data = '0;
    state_t        dbg_state;

    sd_read_ctrl #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_last(resp_last),
        .done(done), .busy(busy),
        .sd_setAddr(sd_setAddr), .sd_addr(sd_addr),
        .sd_ren(sd_ren), .sd_data(sd_data),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    // Helper model: latches its address on setAddr, returns one word per ren
    // at the negedge and advances by one 32-bit word.
    logic [31:0] haddr = '0;
    always @(negedge clock) begin
        if (sd_setAddr) haddr = sd_addr;
        if (sd_ren) begin
            sd_data = word_of(haddr);
            haddr   = haddr + 32'd4;
        end
    end

    int clr_gen = 0;
    int seen_gen = 0;
    int n_setaddr, n_ren, n_valid, n_done;
    int first_setaddr, first_ren, first_valid, first_pop, done_cyc;
    logic [31:0] last_sa_addr;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    always @(negedge clock) begin
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            n_setaddr = 0; n_ren = 0; n_valid = 0; n_done = 0;
            first_setaddr = -1; first_ren = -1; first_valid = -1;
            first_pop = -1; done_cyc = -1; last_sa_addr = '0;
            got_q.delete();
        end
        if (sd_setAddr === 1'b1) begin
            n_setaddr++;
            if (first_setaddr < 0) first_setaddr = cyc;
            last_sa_addr = sd_addr;
        end
        if (sd_ren === 1'b1) begin
            n_ren++;
            if (first_ren < 0) first_ren = cyc;
        end
        if (resp_valid === 1'b1) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
            if (resp_ready) begin
                if (first_pop < 0) first_pop = cyc;
                got_q.push_back({resp_last, resp_data});
            end
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        clr_gen++;
        exp_q.delete();
        @(negedge clock);
        #1;
    endtask

    task automatic build_exp(input logic [31:0] addr, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, word_of(addr + 32'(4 * i))});
        end
    endtask

    task automatic compare_q(input string tag);
        int n;
        check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_eq({tag, "_resp_last"}, 64'(resp_last), 64'd0);
        check_eq({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_setaddr"}, 64'(sd_setAddr), 64'd0);
        check_eq({tag, "_addr"}, 64'(sd_addr), 64'd0);
        check_eq({tag, "_ren"}, 64'(sd_ren), 64'd0);
    endtask

    // Waits for req_ready with req_valid already high; acc is the cycle whose
    // closing edge performs the accept.
    task automatic wait_accept(output int acc);
        bit ok = 0;
        acc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (req_ready === 1'b1) begin
                acc = cyc;
                ok = 1;
                break;
            end
        end
        check_eq("req_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_req(input logic [31:0] addr, input int len, output int acc);
        @(posedge clock);
        #1;
        req_addr  = addr;
        req_len   = LW'(len);
        req_valid = 1'b1;
        wait_accept(acc);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int start_n, input int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (n_done > start_n) begin
                ok = 1;
                break;
            end
        end
        check_eq("done_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_b, done_a;
        bit ok;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single word, consumer always ready.
        clear_stats();
        resp_ready = 1'b1;
        build_exp(32'h200, 1);
        send_req(32'h200, 1, acc);
        wait_done(0, 50);
        check_eq("t1_setaddr_cyc", 64'(first_setaddr), 64'(acc + 1));
        check_eq("t1_setaddr_cnt", 64'(n_setaddr), 64'd1);
        check_eq("t1_setaddr_addr", 64'(last_sa_addr), 64'h200);
        check_eq("t1_ren_cyc", 64'(first_ren), 64'(acc + 2));
        check_eq("t1_ren_cnt", 64'(n_ren), 64'd1);
        check_eq("t1_valid_cyc", 64'(first_valid), 64'(acc + 3));
        check_eq("t1_done_cyc", 64'(done_cyc), 64'(first_pop + 2));
        compare_q("t1");
        @(negedge clock);
        check_eq("t1_idle_ready", 64'(req_ready), 64'd1);

        // Backpressure: FIFO fills after exactly DEPTH reads.
        clear_stats();
        resp_ready = 1'b0;
        build_exp(32'h400, 8);
        send_req(32'h400, 8, acc);
        while (cyc < acc + 20) begin
            @(negedge clock);
            #1;
        end
        check_eq("t2_ren_stalled", 64'(n_ren), 64'd4);
        check_eq("t2_ren_low", 64'(sd_ren), 64'd0);
        check_eq("t2_valid_held", 64'(resp_valid), 64'd1);
        check_eq("t2_head_word0", 64'({resp_last, resp_data}), 64'(exp_q[0]));
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        wait_done(0, 100);
        check_eq("t2_ren_total", 64'(n_ren), 64'd8);
        compare_q("t2");

        // Zero length: straight to DONE.
        clear_stats();
        send_req(32'h800, 0, acc);
        wait_done(0, 20);
        repeat (3) @(negedge clock);
        #1;
        check_eq("t3_done_cyc", 64'(done_cyc), 64'(acc + 1));
        check_eq("t3_setaddr_cnt", 64'(n_setaddr), 64'd0);
        check_eq("t3_ren_cnt", 64'(n_ren), 64'd0);
        check_eq("t3_valid_cnt", 64'(n_valid), 64'd0);

        // Back-to-back: B held valid while A runs.
        clear_stats();
        build_exp(32'h0, 3);
        build_exp(32'h1000, 2);
        send_req(32'h0, 3, acc);
        req_addr  = 32'h1000;
        req_len   = LW'(2);
        req_valid = 1'b1;
        wait_accept(acc_b);
        done_a = done_cyc;
        check_eq("t4_done_before_b", 64'(n_done), 64'd1);
        check_eq("t4_b_accept_cyc", 64'(acc_b), 64'(done_a + 1));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        wait_done(1, 100);
        check_eq("t4_setaddr_cnt", 64'(n_setaddr), 64'd2);
        check_eq("t4_setaddr_b", 64'(last_sa_addr), 64'h1000);
        check_eq("t4_ren_cnt", 64'(n_ren), 64'd5);
        compare_q("t4");

        // Reset in the middle of a read.
        clear_stats();
        resp_ready = 1'b0;
        send_req(32'h5000, 10, acc);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            #1;
            if (n_ren >= 3) begin
                ok = 1;
                break;
            end
        end
        check_eq("t5_three_ren", 64'(ok), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_idle_outputs("t5_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        check_eq("t5_no_more_ren", 64'(n_ren), 64'd3);
        check_eq("t5_setaddr_cnt", 64'(n_setaddr), 64'd1);
        check_eq("t5_still_empty", 64'(resp_valid), 64'd0);
        check_eq("t5_not_busy", 64'(busy), 64'd0);

        // Toggling consumer.
        clear_stats();
        build_exp(32'h6000, 16);
        send_req(32'h6000, 16, acc);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clock);
            #1;
            resp_ready = 1'($urandom_range(0, 1));
            if (n_done > 0) begin
                ok = 1;
                break;
            end
        end
        check_eq("t6_done_seen", 64'(ok), 64'd1);
        check_eq("t6_ren_cnt", 64'(n_ren), 64'd16);
        compare_q("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
